// File: rtl/regfile_wb_ctrl.sv
// Register-file write-back controller.
// Merges single-cycle ALU results and late memory-load data onto the one
// register-file write port. Memory data always owns the port; ALU results
// that lose the port wait in a small in-order FIFO. A pending-destination
// mask of queued ALU writes is exported for issue-side hazard stalls, and a
// sticky flag records any load that overtakes a queued ALU write to the same
// register.
module regfile_wb_ctrl #(
  parameter int DEPTH = 2,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  // ALU result source
  input  logic          alu_valid,
  output logic          alu_ready,
  input  logic          alu_reg_en,
  input  logic [1:0]    alu_dest,
  input  logic [1:0]    alu_cmp_en,
  input  logic [DW-1:0] alu_data,
  // Memory load source (never stalled)
  input  logic          mem_valid,
  input  logic [1:0]    mem_dest,
  input  logic [DW-1:0] mem_data,
  // Register-file write port and compare strobes
  output logic          RegWrite,
  output logic [1:0]    write1,
  output logic [DW-1:0] write_data,
  output logic          sCtrl0,
  output logic          sCtrl1,
  // Hazard reporting
  output logic [3:0]    pend_mask,
  output logic          order_err
);

  // Pointer width covers DEPTH entries; the count needs one extra bit so
  // that a full FIFO (count == DEPTH) is representable.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  // ---------------------------------------------------------------------
  // FIFO storage and bookkeeping
  // ---------------------------------------------------------------------
  logic [DW-1:0] entry_data_q   [DEPTH];
  logic [1:0]    entry_dest_q   [DEPTH];
  logic [1:0]    entry_cmp_q    [DEPTH];
  logic          entry_reg_en_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  // Registered write-port stage
  logic          reg_write_q, reg_write_d;
  logic [1:0]    write1_q,    write1_d;
  logic [DW-1:0] wdata_q,     wdata_d;
  logic          sctrl0_q,    sctrl0_d;
  logic          sctrl1_q,    sctrl1_d;
  logic          order_err_q, order_err_d;

  // Handshake and arbitration decisions
  logic          fifo_nonempty;
  logic          alu_accept;
  logic          push;
  logic          pop;
  logic          bypass;

  // Per-entry liveness and pending-destination contribution
  logic          entry_live [DEPTH];
  logic [3:0]    entry_mask [DEPTH];
  logic [3:0]    pend_mask_comb;

  // Readiness depends only on the registered count; a pop in the same
  // cycle does not open a slot early, which keeps alu_ready free of any
  // path from mem_valid.
  assign alu_ready     = (count_q < CW'(DEPTH));
  assign fifo_nonempty = (count_q != '0);
  assign alu_accept    = alu_valid && alu_ready;

  // A beat is queued whenever it cannot go straight to the port: either
  // memory owns the port, or older ALU entries must retire first.
  assign push   = alu_accept && (mem_valid || fifo_nonempty);
  assign pop    = !mem_valid && fifo_nonempty;
  assign bypass = alu_accept && !mem_valid && !fifo_nonempty;

  // ---------------------------------------------------------------------
  // Pending-destination mask
  // ---------------------------------------------------------------------
  // An entry is live when its distance from the read pointer (modulo the
  // power-of-two depth) is less than the occupancy count.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [PW-1:0] offset;
      assign offset         = PW'(gi) - rd_ptr_q;
      assign entry_live[gi] = ({1'b0, offset} < count_q);
      assign entry_mask[gi] = (entry_live[gi] && entry_reg_en_q[gi])
                              ? (4'b0001 << entry_dest_q[gi])
                              : 4'b0000;
    end
  endgenerate

  // OR together the destinations of every live register-writing entry.
  always_comb begin
    pend_mask_comb = 4'b0000;
    for (int i = 0; i < DEPTH; i++) begin
      pend_mask_comb = pend_mask_comb | entry_mask[i];
    end
  end

  assign pend_mask = pend_mask_comb;

  // ---------------------------------------------------------------------
  // FIFO pointer / count next-state
  // ---------------------------------------------------------------------
  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  // Store an accepted ALU beat at the write pointer; storage needs no reset
  // because liveness is derived from the count.
  always_ff @(posedge clk) begin
    if (push) begin
      entry_data_q[wr_ptr_q]   <= alu_data;
      entry_dest_q[wr_ptr_q]   <= alu_dest;
      entry_cmp_q[wr_ptr_q]    <= alu_cmp_en;
      entry_reg_en_q[wr_ptr_q] <= alu_reg_en;
    end
  end

  // Advance FIFO pointers and occupancy; reset discards all queued entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // ---------------------------------------------------------------------
  // Write-port arbitration: memory, then FIFO head, then bypass, then idle
  // ---------------------------------------------------------------------
  // Select next port contents; address and data hold when the port idles.
  always_comb begin
    reg_write_d = 1'b0;
    write1_d    = write1_q;
    wdata_d     = wdata_q;
    sctrl0_d    = 1'b0;
    sctrl1_d    = 1'b0;
    if (mem_valid) begin
      reg_write_d = 1'b1;
      write1_d    = mem_dest;
      wdata_d     = mem_data;
    end else if (pop) begin
      reg_write_d = entry_reg_en_q[rd_ptr_q];
      write1_d    = entry_dest_q[rd_ptr_q];
      wdata_d     = entry_data_q[rd_ptr_q];
      sctrl0_d    = entry_cmp_q[rd_ptr_q][0];
      sctrl1_d    = entry_cmp_q[rd_ptr_q][1];
    end else if (bypass) begin
      reg_write_d = alu_reg_en;
      write1_d    = alu_dest;
      wdata_d     = alu_data;
      sctrl0_d    = alu_cmp_en[0];
      sctrl1_d    = alu_cmp_en[1];
    end
  end

  // A load overtaking a queued ALU write to the same register is a hazard
  // the issue logic should have stalled; remember it until reset.
  always_comb begin
    order_err_d = order_err_q || (mem_valid && pend_mask_comb[mem_dest]);
  end

  // Register the write port, strobes and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write_q <= 1'b0;
      write1_q    <= 2'b00;
      wdata_q     <= '0;
      sctrl0_q    <= 1'b0;
      sctrl1_q    <= 1'b0;
      order_err_q <= 1'b0;
    end else begin
      reg_write_q <= reg_write_d;
      write1_q    <= write1_d;
      wdata_q     <= wdata_d;
      sctrl0_q    <= sctrl0_d;
      sctrl1_q    <= sctrl1_d;
      order_err_q <= order_err_d;
    end
  end

  assign RegWrite   = reg_write_q;
  assign write1     = write1_q;
  assign write_data = wdata_q;
  assign sCtrl0     = sctrl0_q;
  assign sCtrl1     = sctrl1_q;
  assign order_err  = order_err_q;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed testbench for regfile_wb_ctrl (DEPTH=2, DW=8).
module tb_regfile_wb_ctrl;

  logic       clk;
  logic       rst;
  logic       alu_valid;
  logic       alu_ready;
  logic       alu_reg_en;
  logic [1:0] alu_dest;
  logic [1:0] alu_cmp_en;
  logic [7:0] alu_data;
  logic       mem_valid;
  logic [1:0] mem_dest;
  logic [7:0] mem_data;
  logic       RegWrite;
  logic [1:0] write1;
  logic [7:0] write_data;
  logic       sCtrl0;
  logic       sCtrl1;
  logic [3:0] pend_mask;
  logic       order_err;

  int checks;
  int failures;

  regfile_wb_ctrl #(.DEPTH(2), .DW(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_reg_en (alu_reg_en),
    .alu_dest   (alu_dest),
    .alu_cmp_en (alu_cmp_en),
    .alu_data   (alu_data),
    .mem_valid  (mem_valid),
    .mem_dest   (mem_dest),
    .mem_data   (mem_data),
    .RegWrite   (RegWrite),
    .write1     (write1),
    .write_data (write_data),
    .sCtrl0     (sCtrl0),
    .sCtrl1     (sCtrl1),
    .pend_mask  (pend_mask),
    .order_err  (order_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs and checks happen 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input logic v, input logic en, input logic [1:0] d,
                     input logic [1:0] c, input logic [7:0] x);
    alu_valid  = v;
    alu_reg_en = en;
    alu_dest   = d;
    alu_cmp_en = c;
    alu_data   = x;
  endtask

  task automatic mem(input logic v, input logic [1:0] d, input logic [7:0] x);
    mem_valid = v;
    mem_dest  = d;
    mem_data  = x;
  endtask

  task automatic port(input string tag, input logic we, input logic [1:0] a,
                      input logic [7:0] x);
    $display("txn %s: RegWrite=%0d write1=%0d write_data=%02h", tag, RegWrite, write1, write_data);
    check({tag, ".RegWrite"}, 32'(RegWrite), 32'(we));
    check({tag, ".write1"}, 32'(write1), 32'(a));
    check({tag, ".write_data"}, 32'(write_data), 32'(x));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    alu(1'b0, 1'b0, 2'd0, 2'd0, 8'h00);
    mem(1'b0, 2'd0, 8'h00);
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    port("reset", 1'b0, 2'd0, 8'h00);
    check("reset.sCtrl0", 32'(sCtrl0), 32'd0);
    check("reset.sCtrl1", 32'(sCtrl1), 32'd0);
    check("reset.pend_mask", 32'(pend_mask), 32'h0);
    check("reset.order_err", 32'(order_err), 32'd0);
    check("reset.alu_ready", 32'(alu_ready), 32'd1);

    // Bypass ALU write
    alu(1'b1, 1'b1, 2'd2, 2'b00, 8'h3C);
    tick();
    alu(1'b0, 1'b0, 2'd0, 2'd0, 8'h00);
    port("bypass", 1'b1, 2'd2, 8'h3C);
    check("bypass.pend_mask", 32'(pend_mask), 32'h0);

    // Collision: memory wins, ALU queued
    mem(1'b1, 2'd0, 8'hA5);
    alu(1'b1, 1'b1, 2'd1, 2'b00, 8'h11);
    tick();
    mem(1'b0, 2'd0, 8'h00);
    alu(1'b0, 1'b0, 2'd0, 2'd0, 8'h00);
    port("coll.mem", 1'b1, 2'd0, 8'hA5);
    check("coll.pend_mask", 32'(pend_mask), 32'h2);
    tick();
    port("coll.alu", 1'b1, 2'd1, 8'h11);
    check("coll.pend_clear", 32'(pend_mask), 32'h0);
    tick();
    port("idle.hold", 1'b0, 2'd1, 8'h11);

    // Memory pressure for 4 cycles, ALU beats every cycle
    mem(1'b1, 2'd0, 8'h90);
    alu(1'b1, 1'b1, 2'd1, 2'b00, 8'h21);
    check("press.ready0", 32'(alu_ready), 32'd1);
    tick();
    port("press.m0", 1'b1, 2'd0, 8'h90);
    check("press.ready1", 32'(alu_ready), 32'd1);
    mem(1'b1, 2'd0, 8'h91);
    alu(1'b1, 1'b1, 2'd2, 2'b00, 8'h22);
    tick();
    port("press.m1", 1'b1, 2'd0, 8'h91);
    check("press.ready2", 32'(alu_ready), 32'd0);
    check("press.pend2", 32'(pend_mask), 32'h6);
    mem(1'b1, 2'd0, 8'h92);
    alu(1'b1, 1'b1, 2'd3, 2'b00, 8'h23);
    tick();
    port("press.m2", 1'b1, 2'd0, 8'h92);
    check("press.ready3", 32'(alu_ready), 32'd0);
    mem(1'b1, 2'd0, 8'h93);
    tick();
    port("press.m3", 1'b1, 2'd0, 8'h93);
    check("press.ready4", 32'(alu_ready), 32'd0);
    check("press.pend4", 32'(pend_mask), 32'h6);
    mem(1'b0, 2'd0, 8'h00);
    tick();
    port("drain.0", 1'b1, 2'd1, 8'h21);
    check("drain.ready", 32'(alu_ready), 32'd1);
    check("drain.pend0", 32'(pend_mask), 32'h4);
    tick();
    alu(1'b0, 1'b0, 2'd0, 2'd0, 8'h00);
    port("drain.1", 1'b1, 2'd2, 8'h22);
    check("drain.pend1", 32'(pend_mask), 32'h8);
    tick();
    port("drain.2", 1'b1, 2'd3, 8'h23);
    check("drain.pend2", 32'(pend_mask), 32'h0);
    check("drain.order_err", 32'(order_err), 32'd0);

    // Compare-only ALU entry
    alu(1'b1, 1'b0, 2'd0, 2'b11, 8'h7F);
    tick();
    alu(1'b0, 1'b0, 2'd0, 2'd0, 8'h00);
    port("cmp", 1'b0, 2'd0, 8'h7F);
    check("cmp.sCtrl0", 32'(sCtrl0), 32'd1);
    check("cmp.sCtrl1", 32'(sCtrl1), 32'd1);
    tick();
    check("cmp.sCtrl0_off", 32'(sCtrl0), 32'd0);

    // Ordering hazard: load to a register with a queued ALU write
    mem(1'b1, 2'd0, 8'h55);
    alu(1'b1, 1'b1, 2'd3, 2'b00, 8'h44);
    tick();
    alu(1'b0, 1'b0, 2'd0, 2'd0, 8'h00);
    check("haz.pend", 32'(pend_mask), 32'h8);
    check("haz.err0", 32'(order_err), 32'd0);
    mem(1'b1, 2'd3, 8'h66);
    tick();
    mem(1'b0, 2'd0, 8'h00);
    port("haz.mem", 1'b1, 2'd3, 8'h66);
    check("haz.err1", 32'(order_err), 32'd1);
    tick();
    port("haz.alu", 1'b1, 2'd3, 8'h44);
    tick();
    check("haz.sticky", 32'(order_err), 32'd1);
    check("haz.idle", 32'(RegWrite), 32'd0);

    // Fill FIFO then reset
    mem(1'b1, 2'd0, 8'hB0);
    alu(1'b1, 1'b1, 2'd1, 2'b00, 8'hA1);
    tick();
    mem(1'b1, 2'd0, 8'hB1);
    alu(1'b1, 1'b1, 2'd2, 2'b01, 8'hA2);
    tick();
    mem(1'b0, 2'd0, 8'h00);
    alu(1'b0, 1'b0, 2'd0, 2'd0, 8'h00);
    check("full.ready", 32'(alu_ready), 32'd0);
    check("full.pend", 32'(pend_mask), 32'h6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    port("rst2", 1'b0, 2'd0, 8'h00);
    check("rst2.ready", 32'(alu_ready), 32'd1);
    check("rst2.pend", 32'(pend_mask), 32'h0);
    check("rst2.order_err", 32'(order_err), 32'd0);
    check("rst2.sCtrl0", 32'(sCtrl0), 32'd0);
    tick();
    port("rst2.noissue0", 1'b0, 2'd0, 8'h00);
    tick();
    port("rst2.noissue1", 1'b0, 2'd0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_wb_ctrl.md
Name: regfile_wb_ctrl

Overview:
- Write-back controller that drives the single write port of the 4-entry register file (s1, s2, sp, ra) and the comp0/comp1 strobes.
- Merges two result sources onto that one port: single-cycle ALU results and late-arriving memory-load data.
- Memory data always wins the port. ALU results that collide with memory data are held in a small in-order FIFO.
- Exports a pending-destination mask, used by issue logic for hazard stalls.

Parameters:
- DEPTH, 2, number of ALU entries the FIFO can hold (power of two, 2..8).
- DW, 8, data width of write_data.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- alu_valid  in  1  ALU result present this cycle
- alu_ready  out  1  FIFO can accept an ALU result
- alu_reg_en  in  1  ALU result writes a general register
- alu_dest  in  2  register address: 0=s1, 1=s2, 2=sp, 3=ra
- alu_cmp_en  in  2  bit0 loads comp0, bit1 loads comp1
- alu_data  in  DW  ALU result
- mem_valid  in  1  load data present (never stalled)
- mem_dest  in  2  load destination register
- mem_data  in  DW  load data
- RegWrite  out  1  register-file write enable
- write1  out  2  register-file write address
- write_data  out  DW  register-file write data
- sCtrl0  out  1  comp0 load strobe
- sCtrl1  out  1  comp1 load strobe
- pend_mask  out  4  bit d set while a queued ALU entry targets register d
- order_err  out  1  sticky hazard-violation flag

Behaviour:
- Reset (rst=1 at a clk edge):
  - RegWrite, write1, write_data, sCtrl0, sCtrl1, pend_mask and order_err all go to 0.
  - FIFO count goes to 0. Queued entries are discarded, including during a collision.
  - alu_ready=1 from the first cycle after reset.
- Outputs RegWrite/write1/write_data/sCtrl0/sCtrl1 are registered. Latency from the source cycle to the port is 1 cycle.
- ALU acceptance:
  - An ALU beat is accepted when alu_valid && alu_ready.
  - alu_ready = (count < DEPTH). It depends only on registered state; it does not account for a same-cycle pop.
  - An ALU beat with alu_valid=1 while alu_ready=0 is ignored. The producer must hold it.
- Per-cycle issue priority (one write per cycle):
  1. If mem_valid: next port value = {RegWrite=1, write1=mem_dest, write_data=mem_data, sCtrl0=0, sCtrl1=0}. An accepted ALU beat is pushed.
  2. Else if FIFO is non-empty: pop the head and issue it. An accepted ALU beat is pushed (push and pop in the same cycle; count is unchanged).
  3. Else if an ALU beat is accepted: bypass it directly to the port with no push.
  4. Else: RegWrite=0, sCtrl0=0, sCtrl1=0. write1 and write_data hold their last values.
- Issuing an ALU entry sets:
  - RegWrite=reg_en, write1=dest, write_data=data.
  - sCtrl0=cmp_en[0], sCtrl1=cmp_en[1].
  - An entry with reg_en=0 and cmp_en=0 is still consumed and produces an idle cycle.
- ALU entries retire strictly in acceptance order.
- FIFO pointers wrap modulo DEPTH. Count never exceeds DEPTH and never underflows.
- pend_mask:
  - Combinational OR over valid FIFO entries with reg_en=1 of onehot(dest).
  - A bypassed beat and the registered output stage do not contribute.
- order_err:
  - Set to 1 at a clk edge when mem_valid=1 and pend_mask[mem_dest]=1.
  - Cleared only by rst.
  - The memory write still issues.
- Simultaneous mem_valid with a full FIFO:
  - Memory issues; alu_ready=0, so nothing is pushed.
  - Count stays at DEPTH until the first cycle with mem_valid=0.

Test Plan:
- Reset, then ALU beat {reg_en=1, dest=2, data=0x3C} with mem_valid=0 -> next cycle RegWrite=1, write1=2, write_data=0x3C, pend_mask stays 0x0.
- Same cycle: mem {dest=0, data=0xA5} and ALU {dest=1, data=0x11} -> cycle+1: write1=0, data 0xA5. pend_mask=0x2 during that cycle. Cycle+2: write1=1, data 0x11. pend_mask back to 0x0.
- Hold mem_valid=1 for 4 cycles while driving ALU beats every cycle (DEPTH=2) -> alu_ready drops after 2 accepts. Queued entries then drain in order once mem_valid=0.
- ALU {reg_en=0, cmp_en=2'b11, data=0x7F} -> next cycle sCtrl0=sCtrl1=1, RegWrite=0, write_data=0x7F.
- Queue an ALU entry to dest 3 under mem pressure, then mem_valid with mem_dest=3 -> order_err=1 and stays 1. Memory write to address 3 still issued.
- FIFO full, assert rst for one cycle -> count=0, alu_ready=1, pend_mask=0, order_err=0, RegWrite=0. Pre-reset entries are never issued.
